// File: rtl/array_heap_pkg.sv
// Shared opcode/state types, default geometry and derived widths for the array heap unit.
package array_heap_pkg;

    localparam int N_ARRAYS = 2;
    localparam int N_AREA   = 4;
    localparam int ELEM_W   = 12;

    localparam int AW = (N_ARRAYS > 32'sd1) ? $clog2(N_ARRAYS) : 32'sd1;
    localparam int IW = (N_AREA > 32'sd1) ? $clog2(N_AREA) : 32'sd1;
    localparam int LW = $clog2(N_AREA + 32'sd1);

    typedef enum logic [1:0] {
        OP_WRITE      = 2'd0,
        OP_READ       = 2'd1,
        OP_SHIFT_DOWN = 2'd2,
        OP_SIZE       = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_RESP  = 2'd2
    } state_e;

    // Flat heap slot holding element idx of array arr.
    function automatic int heap_addr(input int arr, input int idx, input int n_area);
        return arr * n_area + idx;
    endfunction

endpackage

// File: rtl/array_heap_ram.sv
// Heap storage: one asynchronous read port and one synchronous write port.
module array_heap_ram
    import array_heap_pkg::*;
#(
    parameter int Width = ELEM_W,
    parameter int Depth = N_ARRAYS * N_AREA,
    parameter int AddrW = 3
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AddrW-1:0] waddr_i,
    input  logic [Width-1:0] wdata_i,
    input  logic [AddrW-1:0] raddr_i,
    output logic [Width-1:0] rdata_o
);

    logic [Width-1:0] mem_q [Depth];

    // Single write per clock; contents are deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (we_i && (int'(waddr_i) < Depth)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = (int'(raddr_i) < Depth) ? mem_q[raddr_i] : '0;

endmodule

// File: rtl/array_shift_down.sv
// Array heap unit: WRITE/READ/SIZE plus SHIFT_DOWN removal that compacts the array one slot per clock.
// Optional ARRAY_SHIFT_DOWN_CLEAR_EN zeroes the vacated top slot in an extra final shift cycle.
module array_shift_down
    import array_heap_pkg::*;
#(
    parameter int MemoryElementWidth = ELEM_W,
    parameter int NArea              = N_AREA,
    parameter int NArrays            = N_ARRAYS
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          cmdValid,
    output logic                          cmdReady,
    input  logic [1:0]                    cmdOp,
    input  logic [AW-1:0]                 cmdArray,
    input  logic [IW-1:0]                 cmdIndex,
    input  logic [MemoryElementWidth-1:0] cmdData,
    output logic                          rspValid,
    input  logic                          rspReady,
    output logic [MemoryElementWidth-1:0] rspData,
    output logic                          rspError
);

    localparam int DEPTH = NArrays * NArea;
    localparam int RAW   = (DEPTH > 32'sd1) ? $clog2(DEPTH) : 32'sd1;
`ifdef ARRAY_SHIFT_DOWN_CLEAR_EN
    localparam int LAST_OFS = 32'sd1;
`else
    localparam int LAST_OFS = 32'sd2;
`endif

    state_e                        state_q;
    logic                          cmd_ready_q;
    logic                          rsp_valid_q;
    logic                          rsp_error_q;
    logic [MemoryElementWidth-1:0] rsp_data_q;
    logic [LW-1:0]                 len_q [NArrays];
    logic [AW-1:0]                 arr_q;
    logic [IW-1:0]                 k_q;

    op_e                           op_s;
    logic                          fire_s;
    logic                          arr_ok_s;
    logic                          idx_area_s;
    logic                          idx_len_s;
    logic [LW-1:0]                 cur_len_s;
    logic [LW-1:0]                 shift_len_s;
    logic                          shift_last_s;
    logic                          shift_clear_s;
    logic                          we_s;
    logic [RAW-1:0]                waddr_s;
    logic [RAW-1:0]                raddr_s;
    logic [MemoryElementWidth-1:0] wdata_s;
    logic [MemoryElementWidth-1:0] rdata_s;
`ifndef ARRAY_SHIFT_DOWN_CLEAR_EN
    logic                          last_elem_s;
`endif

    // Command decode and range checks against the addressed array.
    always_comb begin
        op_s       = op_e'(cmdOp);
        fire_s     = cmdValid && cmd_ready_q && (state_q == ST_IDLE);
        arr_ok_s   = int'(cmdArray) < NArrays;
        idx_area_s = int'(cmdIndex) < NArea;
        if (arr_ok_s) begin
            cur_len_s = len_q[cmdArray];
        end else begin
            cur_len_s = '0;
        end
        idx_len_s   = int'(cmdIndex) < int'(cur_len_s);
`ifndef ARRAY_SHIFT_DOWN_CLEAR_EN
        last_elem_s = (int'(cmdIndex) + 32'sd1) == int'(cur_len_s);
`endif
        shift_len_s  = len_q[arr_q];
        // k walks i..len-2 moving down; with clearing it also visits len-1.
        shift_last_s = (int'(k_q) + LAST_OFS) == int'(shift_len_s);
`ifdef ARRAY_SHIFT_DOWN_CLEAR_EN
        shift_clear_s = shift_last_s;
`else
        shift_clear_s = 1'b0;
`endif
    end

    // Heap port steering: command access in IDLE, one move or clear per SHIFT cycle.
    always_comb begin
        we_s    = 1'b0;
        waddr_s = RAW'(heap_addr(int'(cmdArray), int'(cmdIndex), NArea));
        raddr_s = waddr_s;
        wdata_s = cmdData;
        case (state_q)
            ST_IDLE: begin
                if (fire_s && (op_s == OP_WRITE) && arr_ok_s && idx_area_s) begin
                    we_s = 1'b1;
                end else begin
                    we_s = 1'b0;
                end
            end
            ST_SHIFT: begin
                we_s    = 1'b1;
                waddr_s = RAW'(heap_addr(int'(arr_q), int'(k_q), NArea));
                if (shift_clear_s) begin
                    raddr_s = waddr_s;
                    wdata_s = '0;
                end else begin
                    raddr_s = RAW'(heap_addr(int'(arr_q), int'(k_q) + 32'sd1, NArea));
                    wdata_s = rdata_s;
                end
            end
            default: we_s = 1'b0;
        endcase
    end

    array_heap_ram #(
        .Width (MemoryElementWidth),
        .Depth (DEPTH),
        .AddrW (RAW)
    ) u_ram (
        .clk_i   (clock),
        .we_i    (we_s),
        .waddr_i (waddr_s),
        .wdata_i (wdata_s),
        .raddr_i (raddr_s),
        .rdata_o (rdata_s)
    );

    // Control FSM with registered handshake/response outputs and the length register file.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            rsp_data_q  <= '0;
            arr_q       <= '0;
            k_q         <= '0;
            for (int n = 0; n < NArrays; n++) begin
                len_q[n] <= '0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (fire_s) begin
                        cmd_ready_q <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_error_q <= 1'b0;
                        rsp_data_q  <= '0;
                        state_q     <= ST_RESP;
                        case (op_s)
                            OP_WRITE: begin
                                if (arr_ok_s && idx_area_s) begin
                                    if (!idx_len_s) begin
                                        len_q[cmdArray] <= LW'(int'(cmdIndex) + 32'sd1);
                                    end
                                end else begin
                                    rsp_error_q <= 1'b1;
                                end
                            end
                            OP_READ: begin
                                if (arr_ok_s && idx_len_s) begin
                                    rsp_data_q <= rdata_s;
                                end else begin
                                    rsp_error_q <= 1'b1;
                                end
                            end
                            OP_SHIFT_DOWN: begin
                                if (arr_ok_s && idx_len_s) begin
                                    rsp_data_q <= rdata_s;
                                    arr_q      <= cmdArray;
                                    k_q        <= cmdIndex;
`ifdef ARRAY_SHIFT_DOWN_CLEAR_EN
                                    rsp_valid_q <= 1'b0;
                                    state_q     <= ST_SHIFT;
`else
                                    if (last_elem_s) begin
                                        len_q[cmdArray] <= cur_len_s - LW'(1'b1);
                                    end else begin
                                        rsp_valid_q <= 1'b0;
                                        state_q     <= ST_SHIFT;
                                    end
`endif
                                end else begin
                                    rsp_error_q <= 1'b1;
                                end
                            end
                            OP_SIZE: begin
                                if (arr_ok_s) begin
                                    rsp_data_q <= MemoryElementWidth'(cur_len_s);
                                end else begin
                                    rsp_error_q <= 1'b1;
                                end
                            end
                            default: rsp_error_q <= 1'b1;
                        endcase
                    end else begin
                        cmd_ready_q <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (shift_last_s) begin
                        len_q[arr_q] <= shift_len_s - LW'(1'b1);
                        rsp_valid_q  <= 1'b1;
                        state_q      <= ST_RESP;
                    end else begin
                        k_q <= k_q + IW'(1'b1);
                    end
                end
                ST_RESP: begin
                    if (rspReady) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end else begin
                        rsp_valid_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    cmd_ready_q <= 1'b0;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign cmdReady = cmd_ready_q;
    assign rspValid = rsp_valid_q;
    assign rspData  = rsp_data_q;
    assign rspError = rsp_error_q;

endmodule
